qed_dup_sched: RTL and testbench
================================

# qed_dup_sched

Controller that drives the `exec_dup` mode select of the QED block. It alternates the fetch stream between two phases: an original phase, where originals are issued and captured by the QED instruction cache, and a duplicate phase, where the same number of transformed duplicates are replayed. It holds original fetch whenever duplicates are owed. It sits between the fetch unit and the `qed` instance, and emits a one-cycle `sync_point` pulse at each original/duplicate equivalence point for the QED property checker.

## Interface
Parameters:
- `DEPTH`, 16: maximum originals issued per phase; must be ≥1 and must not exceed the QED i-cache capacity.
- `CNT_W`, `$clog2(DEPTH+1)`: counter width (derived; do not override).

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `ena`  in  1  QED enable; same signal that feeds `qed.ena`.
- `stall_IF`  in  1  fetch stage stalled; no issue this cycle.
- `ifu_vld`  in  1  fetch presents a valid original instruction.
- `is_cf`  in  1  fetched instruction is control-flow (branch/jump); qualified by `ifu_vld`.
- `qed_vld_out`  in  1  QED i-cache has a duplicate ready (`qed.vld_out`).
- `flush`  in  1  pipeline redirect; abandon the current phase.
- `exec_dup`  out  1  registered; 1 = QED muxes duplicates into fetch.
- `fetch_hold`  out  1  combinational; fetch must not advance originals.
- `sync_point`  out  1  registered one-cycle pulse when dup count equals orig count.
- `orig_cnt`  out  `CNT_W`  originals issued in the current phase (debug/checker).

## Operation
- States: IDLE, ORIG, DUP. Outputs are driven as follows:
  - `exec_dup` = (state == DUP).
  - `fetch_hold` = (DUP) or (ORIG and `ifu_vld` and `is_cf` and `orig_cnt` != 0).
- Accepting originals:
  - `orig_acc` = ORIG and `ifu_vld` and !`stall_IF` and !`fetch_hold` and !`is_cf`.
  - On `orig_acc`, `orig_cnt` increments.
  - A control-flow instruction accepted with `orig_cnt` == 0 passes through uncounted and unduplicated.
- Issuing duplicates:
  - `dup_iss` = DUP and `qed_vld_out` and !`stall_IF`.
  - On `dup_iss`, internal `dup_cnt` increments.
- Transitions (priority order `rst` > `flush` > normal):
  - IDLE → ORIG when `ena`.
  - ORIG → DUP when `orig_acc` makes `orig_cnt` == `DEPTH`.
  - ORIG → DUP when `orig_cnt` != 0 and (control-flow held, or `ena` == 0).
  - ORIG → IDLE when `ena` == 0 and `orig_cnt` == 0.
  - DUP → ORIG/IDLE (`ena` selects) when `dup_iss` makes `dup_cnt` == `orig_cnt`. At that point, set `sync_point` and clear both counters.
- Flush: next state = `ena` ? ORIG : IDLE, both counters 0, no `sync_point`.
- Dropping `ena` mid-DUP does not abort the phase; the owed duplicates complete first.
- `dup_cnt` never exceeds `orig_cnt`; `orig_cnt` never exceeds `DEPTH` (assertions).

## Timing
- Reset values: state IDLE, `exec_dup` 0, `sync_point` 0, `orig_cnt` 0, `dup_cnt` 0. `fetch_hold` is 0 while in reset state.
- `exec_dup` rises the cycle after the transition-causing edge. The first duplicate can issue in that same cycle.
- `sync_point` is high for exactly the one cycle in which `exec_dup` returns to 0.
- `stall_IF` freezes both counters; state transitions still follow the rules above.
- `flush` in the same cycle as `orig_acc` or `dup_iss`: `flush` wins and the count is discarded.
- `qed_vld_out` low in DUP: wait with no timeout.

## Structure
- Package `qed_pkg`: state enum (`QS_IDLE`, `QS_ORIG`, `QS_DUP`) and default `DEPTH`, shared with `qed` i-cache sizing.
- Single module, no sub-modules. The counter pair is small enough to stay inline.
- Top-level integration: `exec_dup` → `qed.exec_dup`; `fetch_hold` OR'd into the fetch stall alongside `stall_IF`.

## Test plan
- `rst` held 2 cycles with `ena`=1 and `ifu_vld`=1 → all outputs 0; ORIG entered 1 cycle after `rst` falls.
- `DEPTH`=4, 4 consecutive non-CF originals → `exec_dup`=1 next cycle. Then 4 cycles of `qed_vld_out`=1 → `sync_point` pulse and `exec_dup`=0.
- 2 originals, then `is_cf`=1 → `fetch_hold`=1 and DUP for 2 duplicates. After `sync_point`, CF instruction accepted with `orig_cnt`=0 and stays 0.
- In DUP after 1 of 3 duplicates, `stall_IF`=1 for 3 cycles and `qed_vld_out` low for 2 → counts frozen. `sync_point` arrives only after 2 further issues.
- `flush` asserted on the cycle of the 3rd `orig_acc` → next cycle ORIG, `orig_cnt`=0, no DUP entry, no `sync_point`.
- `ena` dropped with `orig_cnt`=3 → DUP, 3 duplicates, `sync_point`, then IDLE with `fetch_hold`=0.

Source files
------------

// File: rtl/qed_pkg.sv
// qed_pkg: shared QED scheduler state encoding and default i-cache depth.
// Ports: none (package); QED_DEPTH also sizes the qed i-cache.
package qed_pkg;
    localparam int QED_DEPTH = 16;
    typedef enum logic [1:0] {
        QS_IDLE,
        QS_ORIG,
        QS_DUP
    } qs_state_t;
endpackage

// File: rtl/qed_dup_sched_if.sv
// qed_dup_sched_if: fetch-side handshake bundle between fetch, qed and the duplicate scheduler.
// Inputs to scheduler: ena, stall_IF, ifu_vld, is_cf, qed_vld_out, flush.
// Outputs from scheduler: exec_dup, fetch_hold, sync_point, orig_cnt[CNT_W].
interface qed_dup_sched_if
    import qed_pkg::*;
#(
    parameter int DEPTH = QED_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
);
    logic             ena;
    logic             stall_IF;
    logic             ifu_vld;
    logic             is_cf;
    logic             qed_vld_out;
    logic             flush;
    logic             exec_dup;
    logic             fetch_hold;
    logic             sync_point;
    logic [CNT_W-1:0] orig_cnt;
    modport master (
        output ena, stall_IF, ifu_vld, is_cf, qed_vld_out, flush,
        input  exec_dup, fetch_hold, sync_point, orig_cnt
    );
    modport slave (
        input  ena, stall_IF, ifu_vld, is_cf, qed_vld_out, flush,
        output exec_dup, fetch_hold, sync_point, orig_cnt
    );
endinterface

// File: rtl/qed_dup_sched.sv
// qed_dup_sched: alternates fetch between original and duplicate phases and pulses sync_point at equivalence.
// Ports: clk, rst (sync, active-high); bus (slave) carries ena/stall_IF/ifu_vld/is_cf/qed_vld_out/flush in,
// exec_dup (registered), fetch_hold (combinational), sync_point (registered pulse), orig_cnt out.
module qed_dup_sched
    import qed_pkg::*;
#(
    parameter int DEPTH = QED_DEPTH,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic           clk,
    input  logic           rst,
    qed_dup_sched_if.slave bus
);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(DEPTH);

    qs_state_t        r_state, w_state_nxt;
    logic [CNT_W-1:0] r_orig_cnt, r_dup_cnt, w_orig_d, w_dup_d, w_orig_inc, w_dup_inc;
    logic             r_sync, w_sync_d;
    logic             w_cf_hold, w_fetch_hold, w_orig_acc, w_dup_iss;

    always_comb begin
        w_cf_hold    = (r_state == QS_ORIG) && bus.ifu_vld && bus.is_cf && (r_orig_cnt != '0);
        w_fetch_hold = (r_state == QS_DUP) || w_cf_hold;
        w_orig_acc   = (r_state == QS_ORIG) && bus.ifu_vld && !bus.stall_IF && !w_fetch_hold && !bus.is_cf;
        w_dup_iss    = (r_state == QS_DUP) && bus.qed_vld_out && !bus.stall_IF;
        w_orig_inc   = r_orig_cnt + CNT_W'(w_orig_acc);
        w_dup_inc    = r_dup_cnt + CNT_W'(w_dup_iss);
        w_state_nxt  = r_state;
        w_orig_d     = w_orig_inc;
        w_dup_d      = w_dup_inc;
        w_sync_d     = 1'b0;
        case (r_state)
            QS_IDLE: w_state_nxt = bus.ena ? QS_ORIG : QS_IDLE;
            // Post-increment count is used so an original accepted while ena drops is still duplicated.
            QS_ORIG: w_state_nxt = (w_orig_inc == MAX_CNT || w_cf_hold || (!bus.ena && w_orig_inc != '0)) ? QS_DUP
                                 : (!bus.ena ? QS_IDLE : QS_ORIG);
            QS_DUP: begin
                if (w_dup_iss && w_dup_inc == r_orig_cnt) begin
                    w_state_nxt = bus.ena ? QS_ORIG : QS_IDLE;
                    w_orig_d    = '0;
                    w_dup_d     = '0;
                    w_sync_d    = 1'b1;
                end
            end
            default: w_state_nxt = QS_IDLE;
        endcase
        if (bus.flush) begin
            w_state_nxt = bus.ena ? QS_ORIG : QS_IDLE;
            w_orig_d    = '0;
            w_dup_d     = '0;
            w_sync_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= QS_IDLE;
            r_orig_cnt <= '0;
            r_dup_cnt  <= '0;
            r_sync     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_orig_cnt <= w_orig_d;
            r_dup_cnt  <= w_dup_d;
            r_sync     <= w_sync_d;
        end
    end

    assign bus.exec_dup   = (r_state == QS_DUP);
    assign bus.fetch_hold = w_fetch_hold;
    assign bus.sync_point = r_sync;
    assign bus.orig_cnt   = r_orig_cnt;

    a_dup_le_orig: assert property (@(posedge clk) disable iff (rst) r_dup_cnt <= r_orig_cnt);
    a_orig_le_max: assert property (@(posedge clk) disable iff (rst) r_orig_cnt <= MAX_CNT);
endmodule

// File: tb/tb_qed_dup_sched.sv
// tb_qed_dup_sched: directed scenarios plus randomized traffic against a phase/count reference model.
module tb_qed_dup_sched;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    int   m_ph = 0;
    int   m_o = 0;
    int   m_d = 0;
    logic m_sync = 1'b0;
    logic exp_hold, obs_hold;

    qed_dup_sched_if #(.DEPTH(DEPTH)) bus ();
    qed_dup_sched #(.DEPTH(DEPTH)) u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    // m_ph: 0 idle, 1 collecting originals, 2 replaying duplicates
    task automatic cycle(input logic r, e, st, iv, cf, qv, fl);
        logic acc;
        @(negedge clk);
        rst = r;
        bus.ena = e;
        bus.stall_IF = st;
        bus.ifu_vld = iv;
        bus.is_cf = cf;
        bus.qed_vld_out = qv;
        bus.flush = fl;
        #1;
        obs_hold = bus.fetch_hold;
        exp_hold = (m_ph == 2) || (m_ph == 1 && iv && cf && m_o > 0);
        if (r) begin
            m_ph = 0; m_o = 0; m_d = 0; m_sync = 1'b0;
        end else if (fl) begin
            m_ph = e ? 1 : 0; m_o = 0; m_d = 0; m_sync = 1'b0;
        end else begin
            m_sync = 1'b0;
            if (m_ph == 0) begin
                if (e) m_ph = 1;
            end else if (m_ph == 1) begin
                acc = iv && !st && !exp_hold && !cf;
                if (acc) m_o++;
                if (m_o == DEPTH || exp_hold || (!e && m_o > 0)) m_ph = 2;
                else if (!e) m_ph = 0;
            end else if (qv && !st) begin
                m_d++;
                if (m_d == m_o) begin
                    m_sync = 1'b1; m_o = 0; m_d = 0; m_ph = e ? 1 : 0;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic originals(input int n);
        for (int i = 0; i < n; i++) cycle(0, 1, 0, 1, 0, 0, 0);
    endtask

    task automatic restart();
        cycle(0, 1, 0, 0, 0, 0, 1);
    endtask

    task automatic test_reset();
        cycle(1, 1, 0, 1, 0, 0, 0);
        cycle(1, 1, 0, 1, 0, 0, 0);
        n_checks++; if (obs_hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b want 0", obs_hold); end
        n_checks++; if (bus.exec_dup !== 1'b0) begin n_fail++; $display("FAIL reset_exec: got %b want 0", bus.exec_dup); end
        n_checks++; if (bus.sync_point !== 1'b0) begin n_fail++; $display("FAIL reset_sync: got %b want 0", bus.sync_point); end
        n_checks++; if (bus.orig_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.orig_cnt); end
        cycle(0, 1, 0, 1, 0, 0, 0);
        n_checks++; if (bus.orig_cnt !== CNT_W'(0)) begin n_fail++; $display("FAIL reset_first_cnt: got %0d want 0", bus.orig_cnt); end
        cycle(0, 1, 0, 1, 0, 0, 0);
        n_checks++; if (bus.orig_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL reset_orig_entry: got %0d want 1", bus.orig_cnt); end
    endtask

    task automatic test_full_phase();
        restart();
        originals(3);
        n_checks++; if (bus.exec_dup !== 1'b0) begin n_fail++; $display("FAIL full_early_exec: got %b want 0", bus.exec_dup); end
        originals(1);
        n_checks++; if (bus.exec_dup !== 1'b1) begin n_fail++; $display("FAIL full_exec: got %b want 1", bus.exec_dup); end
        n_checks++; if (bus.orig_cnt !== CNT_W'(DEPTH)) begin n_fail++; $display("FAIL full_cnt: got %0d want %0d", bus.orig_cnt, DEPTH); end
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0, 1, 0);
        n_checks++; if (obs_hold !== 1'b1) begin n_fail++; $display("FAIL full_dup_hold: got %b want 1", obs_hold); end
        n_checks++; if (bus.sync_point !== 1'b0) begin n_fail++; $display("FAIL full_early_sync: got %b want 0", bus.sync_point); end
        cycle(0, 1, 0, 0, 0, 1, 0);
        n_checks++; if (bus.sync_point !== 1'b1) begin n_fail++; $display("FAIL full_sync: got %b want 1", bus.sync_point); end
        n_checks++; if (bus.exec_dup !== 1'b0) begin n_fail++; $display("FAIL full_exec_off: got %b want 0", bus.exec_dup); end
        n_checks++; if (bus.orig_cnt !== '0) begin n_fail++; $display("FAIL full_cnt_clr: got %0d want 0", bus.orig_cnt); end
        cycle(0, 1, 0, 0, 0, 0, 0);
        n_checks++; if (bus.sync_point !== 1'b0) begin n_fail++; $display("FAIL full_sync_pulse: got %b want 0", bus.sync_point); end
    endtask

    task automatic test_cf_hold();
        restart();
        originals(2);
        cycle(0, 1, 0, 1, 1, 0, 0);
        n_checks++; if (obs_hold !== 1'b1) begin n_fail++; $display("FAIL cf_hold: got %b want 1", obs_hold); end
        n_checks++; if (bus.exec_dup !== 1'b1) begin n_fail++; $display("FAIL cf_exec: got %b want 1", bus.exec_dup); end
        cycle(0, 1, 0, 1, 1, 1, 0);
        cycle(0, 1, 0, 1, 1, 1, 0);
        n_checks++; if (bus.sync_point !== 1'b1) begin n_fail++; $display("FAIL cf_sync: got %b want 1", bus.sync_point); end
        cycle(0, 1, 0, 1, 1, 0, 0);
        n_checks++; if (obs_hold !== 1'b0) begin n_fail++; $display("FAIL cf_pass_hold: got %b want 0", obs_hold); end
        n_checks++; if (bus.orig_cnt !== '0) begin n_fail++; $display("FAIL cf_pass_cnt: got %0d want 0", bus.orig_cnt); end
        n_checks++; if (bus.exec_dup !== 1'b0) begin n_fail++; $display("FAIL cf_pass_exec: got %b want 0", bus.exec_dup); end
    endtask

    task automatic test_stall();
        restart();
        originals(3);
        cycle(0, 1, 0, 1, 1, 0, 0);
        cycle(0, 1, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 2; i++) cycle(0, 1, 0, 0, 0, 0, 0);
        n_checks++; if (bus.exec_dup !== 1'b1) begin n_fail++; $display("FAIL stall_exec: got %b want 1", bus.exec_dup); end
        cycle(0, 1, 0, 0, 0, 1, 0);
        n_checks++; if (bus.sync_point !== 1'b0) begin n_fail++; $display("FAIL stall_early_sync: got %b want 0", bus.sync_point); end
        n_checks++; if (bus.orig_cnt !== CNT_W'(3)) begin n_fail++; $display("FAIL stall_cnt: got %0d want 3", bus.orig_cnt); end
        cycle(0, 1, 0, 0, 0, 1, 0);
        n_checks++; if (bus.sync_point !== 1'b1) begin n_fail++; $display("FAIL stall_sync: got %b want 1", bus.sync_point); end
    endtask

    task automatic test_flush();
        restart();
        originals(2);
        cycle(0, 1, 0, 1, 0, 0, 1);
        n_checks++; if (bus.orig_cnt !== '0) begin n_fail++; $display("FAIL flush_cnt: got %0d want 0", bus.orig_cnt); end
        n_checks++; if (bus.exec_dup !== 1'b0) begin n_fail++; $display("FAIL flush_exec: got %b want 0", bus.exec_dup); end
        n_checks++; if (bus.sync_point !== 1'b0) begin n_fail++; $display("FAIL flush_sync: got %b want 0", bus.sync_point); end
        originals(1);
        n_checks++; if (bus.orig_cnt !== CNT_W'(1)) begin n_fail++; $display("FAIL flush_orig: got %0d want 1", bus.orig_cnt); end
    endtask

    task automatic test_ena_drop();
        restart();
        originals(3);
        cycle(0, 0, 0, 0, 0, 0, 0);
        n_checks++; if (bus.exec_dup !== 1'b1) begin n_fail++; $display("FAIL ena_exec: got %b want 1", bus.exec_dup); end
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1, 0);
        n_checks++; if (bus.sync_point !== 1'b1) begin n_fail++; $display("FAIL ena_sync: got %b want 1", bus.sync_point); end
        n_checks++; if (bus.exec_dup !== 1'b0) begin n_fail++; $display("FAIL ena_exec_off: got %b want 0", bus.exec_dup); end
        cycle(0, 0, 0, 1, 0, 0, 0);
        n_checks++; if (obs_hold !== 1'b0) begin n_fail++; $display("FAIL ena_idle_hold: got %b want 0", obs_hold); end
        n_checks++; if (bus.orig_cnt !== '0) begin n_fail++; $display("FAIL ena_idle_cnt: got %0d want 0", bus.orig_cnt); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 29) == 0);
            n_checks++; if (obs_hold !== exp_hold) begin n_fail++; $display("FAIL rnd_hold @%0d: got %b want %b", i, obs_hold, exp_hold); end
            n_checks++; if (bus.exec_dup !== (m_ph == 2)) begin n_fail++; $display("FAIL rnd_exec @%0d: got %b want %b", i, bus.exec_dup, m_ph == 2); end
            n_checks++; if (bus.sync_point !== m_sync) begin n_fail++; $display("FAIL rnd_sync @%0d: got %b want %b", i, bus.sync_point, m_sync); end
            n_checks++; if (bus.orig_cnt !== CNT_W'(m_o)) begin n_fail++; $display("FAIL rnd_cnt @%0d: got %0d want %0d", i, bus.orig_cnt, m_o); end
        end
    endtask

    initial begin
        bus.ena = 1'b0;
        bus.stall_IF = 1'b0;
        bus.ifu_vld = 1'b0;
        bus.is_cf = 1'b0;
        bus.qed_vld_out = 1'b0;
        bus.flush = 1'b0;
        test_reset();
        test_full_phase();
        test_cf_hold();
        test_stall();
        test_flush();
        test_ena_drop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
